// File: rtl/fb_pkg.sv
// Shared types and constants for the triple-buffered framebuffer scheduler.
package fb_pkg;

    typedef logic [1:0] bank_idx_t;

    typedef enum logic {
        CLEAR = 1'b0,
        WAIT  = 1'b1
    } sched_state_t;

    localparam int FB_PIXELS = 307200;
    localparam int FB_AW     = 19;

    localparam bank_idx_t RST_DISP = 2'd0;
    localparam bank_idx_t RST_DRAW = 2'd1;
    localparam bank_idx_t RST_CLR  = 2'd2;

endpackage

// File: rtl/fb_clear_counter.sv
// Clear-engine address counter: counts 0..PIXELS-1 while enabled, flags the last address.
module fb_clear_counter
    import fb_pkg::*;
#(
    parameter int PIXELS = FB_PIXELS,
    parameter int AW     = FB_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          en,
    output logic [AW-1:0] addr,
    output logic          last
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(PIXELS - 1);

    // The owner restarts the count on the terminal address, so it never wraps past PIXELS-1.
    always_ff @(posedge clk) begin
        if (!rst || start) begin
            addr <= '0;
        end else if (en) begin
            addr <= addr + 1'b1;
        end
    end

    assign last = (addr == LAST_ADDR);

endmodule

// File: rtl/fb_swap_scheduler.sv
// Triple-buffer role scheduler: rotates display/draw/clear banks at frame end once
// drawing is done and the clear bank is fully cleared; drives the clear engine.
module fb_swap_scheduler
    import fb_pkg::*;
#(
    parameter int              PIXELS      = FB_PIXELS,
    parameter int              AW          = FB_AW,
    parameter int              CW          = 4,
    parameter logic [CW-1:0]   CLEAR_COLOR = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          eof,
    input  logic          draw_done,
    output logic [1:0]    disp_sel,
    output logic [1:0]    draw_sel,
    output logic [1:0]    clr_sel,
    output logic [AW-1:0] clr_addr,
    output logic          clr_we,
    output logic [CW-1:0] clr_data,
    output logic          draw_ready,
    output logic          swap,
    output logic [15:0]   stall_cnt
);

    sched_state_t state;
    logic         done_latch;
    logic         done_next;
    logic         swap_now;
    logic         clr_last;
    logic         clr_start;

    assign swap_now  = (state == WAIT) && eof && done_latch;
    assign clr_start = swap_now || ((state == CLEAR) && clr_last);
    // A swap clears the latch even if draw_done arrives in the same cycle.
    assign done_next = swap_now ? 1'b0 : (draw_done ? 1'b1 : done_latch);

    assign clr_data = CLEAR_COLOR;

    fb_clear_counter #(
        .PIXELS (PIXELS),
        .AW     (AW)
    ) u_clear_counter (
        .clk   (clk),
        .rst   (rst),
        .start (clr_start),
        .en    (state == CLEAR),
        .addr  (clr_addr),
        .last  (clr_last)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= CLEAR;
            clr_we     <= 1'b1;
            disp_sel   <= RST_DISP;
            draw_sel   <= RST_DRAW;
            clr_sel    <= RST_CLR;
            done_latch <= 1'b0;
            draw_ready <= 1'b1;
            swap       <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            swap       <= swap_now;
            done_latch <= done_next;
            draw_ready <= ~done_next;

            case (state)
                CLEAR: begin
                    if (clr_last) begin
                        state  <= WAIT;
                        clr_we <= 1'b0;
                    end
                end
                WAIT: begin
                    if (swap_now) begin
                        disp_sel <= draw_sel;
                        draw_sel <= clr_sel;
                        clr_sel  <= disp_sel;
                        state    <= CLEAR;
                        clr_we   <= 1'b1;
                    end
                end
                default: begin
                    state  <= CLEAR;
                    clr_we <= 1'b1;
                end
            endcase

            if (eof && !swap_now && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fb_swap_scheduler.sv
// Self-checking bench for fb_swap_scheduler: role-rotation model plus directed vectors.
module tb_fb_swap_scheduler;

    localparam int            P  = 100;
    localparam int            AW = 19;
    localparam logic [3:0]    CC = 4'hA;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          eof = 1'b0;
    logic          draw_done = 1'b0;
    logic [1:0]    disp_sel, draw_sel, clr_sel;
    logic [AW-1:0] clr_addr;
    logic          clr_we;
    logic [3:0]    clr_data;
    logic          draw_ready, swap;
    logic [15:0]   stall_cnt;

    int tests = 0;
    int fails = 0;
    bit active = 1'b0;

    always #5 clk = ~clk;

    fb_swap_scheduler #(
        .PIXELS      (P),
        .AW          (AW),
        .CW          (4),
        .CLEAR_COLOR (CC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .eof        (eof),
        .draw_done  (draw_done),
        .disp_sel   (disp_sel),
        .draw_sel   (draw_sel),
        .clr_sel    (clr_sel),
        .clr_addr   (clr_addr),
        .clr_we     (clr_we),
        .clr_data   (clr_data),
        .draw_ready (draw_ready),
        .swap       (swap),
        .stall_cnt  (stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: roles are a rotation index, the clear is a count of cycles remaining.
    int m_rot, m_left, m_stall;
    bit m_done, m_swap, go;

    always @(posedge clk) begin
        if (!rst) begin
            m_rot = 0; m_left = P; m_done = 0; m_stall = 0; m_swap = 0;
        end else begin
            go = (m_left == 0) && eof && m_done;
            m_swap = go;
            if (go) begin
                m_rot = (m_rot + 1) % 3;
                m_left = P;
                m_done = 0;
            end else begin
                if (m_left > 0) m_left--;
                if (draw_done) m_done = 1;
                if (eof && m_stall < 65535) m_stall++;
            end
        end
    end

    always @(negedge clk) begin
        if (active) begin
            chk("disp_sel", disp_sel, m_rot);
            chk("draw_sel", draw_sel, (m_rot + 1) % 3);
            chk("clr_sel", clr_sel, (m_rot + 2) % 3);
            chk("clr_we", clr_we, m_left > 0);
            chk("clr_addr", clr_addr, (m_left > 0) ? P - m_left : 0);
            chk("draw_ready", draw_ready, !m_done);
            chk("swap", swap, m_swap);
            chk("stall_cnt", stall_cnt, m_stall);
            chk("clr_data", clr_data, CC);
            chk("bank_perm", (32'd1 << disp_sel) | (32'd1 << draw_sel) | (32'd1 << clr_sel), 7);
        end
    end

    task automatic pulse(input bit e, input bit d);
        eof = e;
        draw_done = d;
        @(negedge clk);
        eof = 1'b0;
        draw_done = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (clr_we && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle_timeout", n < 1000, 1);
    endtask

    task automatic wait_addr(input int a);
        int n = 0;
        while (!(clr_we && clr_addr == AW'(a)) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_addr_timeout", n < 1000, 1);
    endtask

    task automatic chk_banks(input string tag, input int d, input int w, input int c);
        chk({tag, "_disp"}, disp_sel, d);
        chk({tag, "_draw"}, draw_sel, w);
        chk({tag, "_clr"}, clr_sel, c);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        active = 1'b1;
        chk_banks("reset", 0, 1, 2);
        chk("reset_addr", clr_addr, 0);
        chk("reset_we", clr_we, 1);
        chk("reset_stall", stall_cnt, 0);
        chk("reset_ready", draw_ready, 1);
        chk("reset_swap", swap, 0);
        rst = 1'b1;

        // Full clear lasts exactly P cycles.
        n = 0;
        while (clr_we && n < 1000) begin
            chk("clear_seq_addr", clr_addr, n);
            n++;
            @(negedge clk);
        end
        chk("clear_len", n, P);
        chk("wait_addr0", clr_addr, 0);

        // draw_done, then eof five cycles later.
        pulse(0, 1);
        chk("ready_fall", draw_ready, 0);
        repeat (4) @(negedge clk);
        pulse(1, 0);
        chk("swap1", swap, 1);
        chk_banks("swap1", 1, 2, 0);
        chk("swap1_ready", draw_ready, 1);
        chk("swap1_addr", clr_addr, 0);
        chk("swap1_we", clr_we, 1);
        @(negedge clk);
        chk("swap1_one_cycle", swap, 0);

        wait_idle();
        pulse(0, 1);
        pulse(1, 0);
        chk_banks("swap2", 2, 0, 1);
        wait_idle();
        pulse(0, 1);
        pulse(1, 0);
        chk_banks("swap3", 0, 1, 2);

        // Coincident draw_done and eof stalls; the next eof swaps.
        wait_idle();
        pulse(1, 1);
        chk("coinc_swap", swap, 0);
        chk("coinc_stall", stall_cnt, 1);
        pulse(1, 0);
        chk("coinc_next_swap", swap, 1);
        chk("coinc_next_stall", stall_cnt, 1);

        // eof during clear never swaps, including on the last address.
        pulse(0, 1);
        wait_addr(10);
        pulse(1, 0);
        chk("clr_mid_swap", swap, 0);
        chk("clr_mid_stall", stall_cnt, 2);
        wait_addr(P - 1);
        pulse(1, 0);
        chk("clr_last_swap", swap, 0);
        chk("clr_last_stall", stall_cnt, 3);
        chk("clr_last_we", clr_we, 0);
        pulse(1, 0);
        chk("wait_swap", swap, 1);
        chk_banks("wait_swap", 2, 0, 1);

        // Reset in mid-clear.
        wait_addr(50);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk_banks("midrst", 0, 1, 2);
        chk("midrst_addr", clr_addr, 0);
        chk("midrst_stall", stall_cnt, 0);
        chk("midrst_ready", draw_ready, 1);
        chk("midrst_we", clr_we, 1);

        // Back-to-back eof pulses drive the stall counter into saturation.
        eof = 1'b1;
        repeat (65540) @(negedge clk);
        eof = 1'b0;
        chk("sat_stall", stall_cnt, 16'hFFFF);
        pulse(1, 0);
        pulse(1, 0);
        chk("sat_hold", stall_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
